// File: rtl/cpu_nic.sv
// NIC between the processor's load/store port and the mesh router's local port.
// One single-entry buffer per direction, each with a full flag.
module cpu_nic #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [1:0]            addr_nic,
    input  logic [0:DATA_WIDTH-1] d_in_nic,
    output logic [0:DATA_WIDTH-1] d_out_nic,
    input  logic                  nicEn,
    input  logic                  nicWrEn,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [0:DATA_WIDTH-1] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [0:DATA_WIDTH-1] net_do,
    input  logic                  net_polarity
);

    logic [0:DATA_WIDTH-1] in_buf;
    logic [0:DATA_WIDTH-1] out_buf;
    logic                  in_full;
    logic                  out_full;
    logic                  cpu_rd;
    logic                  cpu_wr;

    assign cpu_rd = nicEn & ~nicWrEn;
    assign cpu_wr = nicEn & nicWrEn;

    assign net_ri = ~in_full;
    // Bit 0 is the VC bit; it must match the router's current polarity to send.
    assign net_so = out_full & net_ro & (out_buf[0] == net_polarity);
    assign net_do = out_buf;

    always_comb begin
        d_out_nic = '0;
        if (cpu_rd) begin
            case (addr_nic)
                2'b00: d_out_nic = in_buf;
                2'b01: d_out_nic[DATA_WIDTH-1] = in_full;
                2'b10: d_out_nic = '0;
                2'b11: d_out_nic[DATA_WIDTH-1] = out_full;
                default: d_out_nic = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            in_buf   <= '0;
            in_full  <= 1'b0;
            out_buf  <= '0;
            out_full <= 1'b0;
        end else begin
            if (cpu_rd && addr_nic == 2'b00)
                in_full <= 1'b0;
            // net_ri is low whenever a read could clear a full buffer, so these never collide.
            if (net_si && net_ri) begin
                in_buf  <= net_di;
                in_full <= 1'b1;
            end
            if (net_so) begin
                out_full <= 1'b0;
            end else if (cpu_wr && addr_nic == 2'b10 && !out_full) begin
                out_buf  <= d_in_nic;
                out_full <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_cpu_nic.sv
// Scoreboard bench for cpu_nic: a queue-based reference model predicts each
// cycle's outputs; a negedge monitor pops and compares them.
module tb_cpu_nic;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  addr_nic;
    logic [63:0] d_in_nic;
    logic [63:0] d_out_nic;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    cpu_nic #(.DATA_WIDTH(64)) dut (
        .clk(clk), .reset(reset), .addr_nic(addr_nic), .d_in_nic(d_in_nic),
        .d_out_nic(d_out_nic), .nicEn(nicEn), .nicWrEn(nicWrEn),
        .net_si(net_si), .net_ri(net_ri), .net_di(net_di), .net_so(net_so),
        .net_ro(net_ro), .net_do(net_do), .net_polarity(net_polarity)
    );

    always #5 clk = ~clk;

    typedef struct {
        int unsigned cyc;
        logic [63:0] dout;
        logic        ri;
        logic        so;
        logic [63:0] dov;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int unsigned cyc = 0;
    int          checks = 0;
    int          errors = 0;

    // Reference model: each direction is a one-slot queue plus the last value written.
    logic [63:0] in_q[$];
    logic [63:0] out_q[$];
    logic [63:0] in_last;
    logic [63:0] out_last;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            checks++;
            errors++;
            $display("FAIL stale_entry cyc=%0d got=none exp=entry_for_%0d", cyc, sb[0].cyc);
            void'(sb.pop_front());
        end
        if (sb.size() > 0 && sb[0].cyc == cyc) begin
            mon_e = sb.pop_front();
            chk("d_out_nic", d_out_nic, mon_e.dout);
            chk("net_ri", {63'd0, net_ri}, {63'd0, mon_e.ri});
            chk("net_so", {63'd0, net_so}, {63'd0, mon_e.so});
            chk("net_do", net_do, mon_e.dov);
        end
    end

    task automatic model_reset();
        in_q.delete();
        out_q.delete();
        in_last  = '0;
        out_last = '0;
    endtask

    task automatic step(input logic en, input logic we, input logic [1:0] a,
                        input logic [63:0] d, input logic si, input logic [63:0] di,
                        input logic ro, input logic pol);
        exp_t e;
        logic out_was_full;
        nicEn = en; nicWrEn = we; addr_nic = a; d_in_nic = d;
        net_si = si; net_di = di; net_ro = ro; net_polarity = pol;
        e.cyc  = cyc;
        e.ri   = (in_q.size() == 0);
        e.so   = (out_q.size() == 1) && ro && (out_q[0][63] == pol);
        e.dov  = out_last;
        e.dout = '0;
        if (en && !we) begin
            case (a)
                2'd0: e.dout = in_last;
                2'd1: e.dout = 64'(in_q.size());
                2'd2: e.dout = '0;
                2'd3: e.dout = 64'(out_q.size());
                default: e.dout = '0;
            endcase
        end
        sb.push_back(e);
        @(posedge clk);
        out_was_full = (out_q.size() != 0);
        if (en && !we && a == 2'd0) in_q.delete();
        if (si && e.ri) begin
            in_q.push_back(di);
            in_last = di;
        end
        if (e.so) void'(out_q.pop_front());
        else if (en && we && a == 2'd2 && !out_was_full) begin
            out_q.push_back(d);
            out_last = d;
        end
        #1;
    endtask

    task automatic idle(input logic ro, input logic pol);
        step(1'b0, 1'b0, 2'd0, '0, 1'b0, '0, ro, pol);
    endtask

    localparam logic [63:0] PKT_A = 64'h8000_0000_0000_00AB;
    localparam logic [63:0] PKT_B = 64'h0000_0000_0000_0055;
    localparam logic [63:0] BEEF  = 64'h0000_0000_DEAD_BEEF;
    localparam logic [63:0] ONES  = '1;

    initial begin
        reset = 1'b1;
        nicEn = 0; nicWrEn = 0; addr_nic = 0; d_in_nic = 0;
        net_si = 0; net_di = 0; net_ro = 0; net_polarity = 0;
        model_reset();
        #3;
        chk("reset_ri", {63'd0, net_ri}, 64'd1);
        chk("reset_so", {63'd0, net_so}, 64'd0);
        chk("reset_do", net_do, 64'd0);
        chk("reset_dout", d_out_nic, 64'd0);
        @(posedge clk); #1 reset = 1'b0;

        // CPU send with matching polarity
        step(1, 1, 2'd2, PKT_A, 0, '0, 1, 1);
        step(1, 0, 2'd3, '0, 0, '0, 1, 1);
        step(1, 0, 2'd3, '0, 0, '0, 1, 1);

        // Polarity gating: VC bit 0 waits for polarity 0
        step(1, 1, 2'd2, PKT_B, 0, '0, 1, 1);
        repeat (3) idle(1, 1);
        idle(1, 0);
        idle(1, 0);

        // Full output buffer drops the second write
        step(1, 1, 2'd2, PKT_A, 0, '0, 0, 1);
        step(1, 1, 2'd2, 64'h1, 0, '0, 0, 1);
        idle(0, 1);
        idle(1, 1);
        idle(1, 1);

        // Router receive, second send held off until the read
        step(0, 0, 2'd0, '0, 1, BEEF, 0, 0);
        step(1, 0, 2'd1, '0, 1, 64'h1234, 0, 0);
        step(1, 0, 2'd0, '0, 1, 64'h1234, 0, 0);
        step(1, 0, 2'd1, '0, 1, 64'h5678, 0, 0);
        step(1, 0, 2'd0, '0, 0, '0, 0, 0);
        step(1, 0, 2'd0, '0, 0, '0, 0, 0);

        // Address decode: reads of 10, writes to non-output addresses ignored
        step(1, 0, 2'd2, '0, 0, '0, 0, 0);
        step(1, 1, 2'd0, ONES, 0, '0, 0, 0);
        step(1, 1, 2'd1, ONES, 0, '0, 0, 0);
        step(1, 1, 2'd3, ONES, 0, '0, 0, 0);
        step(1, 0, 2'd0, '0, 0, '0, 0, 0);
        step(1, 0, 2'd1, '0, 0, '0, 0, 0);
        step(1, 0, 2'd3, '0, 0, '0, 0, 0);

        // Async reset mid-cycle with both buffers full
        step(1, 1, 2'd2, PKT_A, 0, '0, 0, 1);
        step(0, 0, 2'd0, '0, 1, BEEF, 0, 1);
        nicEn = 1; nicWrEn = 0; addr_nic = 2'd0; net_ro = 1; net_polarity = 1;
        #2 reset = 1'b1;
        #1;
        chk("async_rst_so", {63'd0, net_so}, 64'd0);
        chk("async_rst_ri", {63'd0, net_ri}, 64'd1);
        chk("async_rst_dout", d_out_nic, 64'd0);
        @(posedge clk); #1 reset = 1'b0;
        model_reset();
        step(1, 0, 2'd3, '0, 0, '0, 1, 1);
        step(1, 0, 2'd1, '0, 0, '0, 1, 1);

        // Randomized traffic
        repeat (400) begin
            step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom(), $urandom()}, 1'($urandom_range(0, 1)), {$urandom(), $urandom()},
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        @(posedge clk);
        @(posedge clk);
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain got=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
